// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder/subtractor.
// The FSM walks IDLE -> CALC -> DONE -> IDLE.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder composed of two half adders and an OR of their carries.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  halfadd u_ha0 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_s1),
    .o_c (w_c1)
  );

  halfadd u_ha1 (
    .i_a (w_s1),
    .i_b (i_ci),
    .o_s (o_s),
    .o_c (w_c2)
  );

  assign o_co = w_c1 | w_c2;

endmodule

// File: rtl/halfadd.sv
// Combinational half adder: sum and carry of two bits.
module halfadd (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell processes operands LSB-first,
// one bit per clock, between a valid/ready input and a valid/ready output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_shift;
  logic [CntW-1:0]  r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

  full_adder u_fa (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  assign w_accept = (r_state == StIdle) && i_in_valid;
  assign w_last   = (r_state == StCalc) && (r_cnt == CntW'(WIDTH - 1));

  // New sum bit enters at the MSB so bit 0 lands in place after WIDTH shifts.
  always_comb begin
    w_sum_shift            = r_sum >> 1;
    w_sum_shift[WIDTH-1]   = w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_in_valid) w_state_next = StCalc;
      StCalc:  if (w_last) w_state_next = StDone;
      StDone:  if (i_out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == StIdle);
    o_out_valid = (r_state == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_sub ? ~i_b : i_b;
      r_carry <= i_sub | i_cin;
      r_cnt   <= '0;
    end else if (r_state == StCalc) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= w_sum_shift;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CntW'(1);
      if (w_last) begin
        r_cout <= w_co;
        r_ovf  <= r_carry ^ w_co;
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor and the multi-cycle successor to the combinational half adder. It accepts two WIDTH-bit operands through a valid/ready handshake. It then computes the result LSB-first, one bit per clock, using a single full-adder cell and a carry flip-flop, and returns the result through a second valid/ready handshake. It is intended for area-constrained datapaths where WIDTH cycles of latency are acceptable.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range 1..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = A+B+cin, 1 = A−B.
- out_valid  output  1  sum, cout and ovf are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; in subtract mode, 1 means no borrow.
- ovf  output  1  signed overflow, defined as (carry into MSB) XOR cout.

One clock. Reset is asynchronous and active-low (clk, rst_n).

## Operation
- FSM states: IDLE → CALC → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the block loads shift register A←a and shift register B←(sub ? ~b : b).
  - It loads the carry flip-flop with (sub ? 1 : cin), clears the bit counter to 0, and enters CALC.
- CALC: each edge performs the following:
  - s = A[0]^B[0]^carry.
  - carry ← majority(A[0], B[0], carry).
  - A and B shift right; s shifts into the sum register at the MSB, so after WIDTH shifts sum[0] holds bit 0.
  - The counter increments.
  - On the edge where counter == WIDTH−1, the block also captures carry-in-to-MSB (the current carry value) for ovf and enters DONE.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are held stable while out_ready=0.
  - On an edge with out_ready=1, the block enters IDLE.
- in_valid is ignored in CALC and DONE; the handshake does not drop the operands, it simply does not complete.
- The block does not accept a new input while out_valid is high; there is no bypass from DONE to CALC.
- Counter width is $clog2(WIDTH+1). With WIDTH=1, CALC lasts exactly one cycle.
- Outputs in DONE depend only on registers; there is no combinational path from inputs to outputs other than none.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, counter=0, carry=0.
- If rst_n is asserted mid-CALC or in DONE, the block enters the reset state immediately. The partial result is discarded and no out_valid pulse occurs.
- Latency: operands accepted at edge k → out_valid high after edge k+WIDTH.
- Minimum throughput: one result per WIDTH+2 cycles when out_ready is held at 1.
- in_ready falls after the accepting edge and rises after the edge that completes the output handshake.
- Simultaneous out_ready=1 and in_valid=1 in DONE: the result is consumed, and the input is not accepted until the next cycle (IDLE).
- Arithmetic is modulo 2^WIDTH.
- The ovf rule is the same for add and subtract.

## Structure
- Package serial_adder_pkg: state enum (IDLE, CALC, DONE) with 2-bit encoding.
- Sub-module full_adder (a, b, ci → s, co), built from two existing halfadd instances plus an OR gate. This reuses the verified half adder and is instantiated once in the CALC datapath.
- Top level contains the FSM, shift registers, counter, carry flip-flop and output registers.

## Test plan
All cases use WIDTH=8 unless noted.
1. a=0x0F, b=0x01, sub=0, cin=0 → sum=0x10, cout=0, ovf=0. out_valid rises exactly 8 cycles after acceptance.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1.
3. sub=1, a=0x05, b=0x07 → sum=0xFE, cout=0, ovf=0. sub=1, a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
4. Back-pressure: hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0. Pulse in_valid in the same window → not accepted.
5. Reset mid-operation: assert rst_n=0 at CALC bit 3 → all outputs take reset values at once. The next transaction, 0x12+0x34, gives 0x46.
6. WIDTH=1: all four combinations of (a,b) with cin=0 → sum/cout match the half-adder truth table (0/0, 1/0, 1/0, 0/1), each with 1-cycle latency.
